// File: rtl/usr_ctrl_if.sv
// Command handshake bundle for the universal-shift-register sequencer.
// The master issues commands; the slave (usr_ctrl) raises cmd_ready when it can accept one.
interface usr_ctrl_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 3
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_cnt;
    logic [WIDTH-1:0] cmd_din;
    logic             cmd_sin;

    modport master (
        output cmd_valid, cmd_op, cmd_cnt, cmd_din, cmd_sin,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_cnt, cmd_din, cmd_sin,
        output cmd_ready
    );
endinterface

// File: rtl/usr_ctrl.sv
// Command sequencer for a 4-bit universal shift register: load, multi-cycle shift, clear.
// Optional macro USR_ROTATE_EN turns op 11 into rotate-right by cnt.
module usr_ctrl #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    usr_ctrl_if.slave        cmd,
    input  logic [WIDTH-1:0] usr_q,
    output logic [1:0]       usr_sel,
    output logic [WIDTH-1:0] usr_pdata,
    output logic             usr_sr_in,
    output logic             usr_sl_in,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    localparam logic [1:0] OpLoad  = 2'b00;
    localparam logic [1:0] OpShr   = 2'b01;
    localparam logic [1:0] OpShl   = 2'b10;
    localparam logic [1:0] SelHold = 2'b00;
    localparam logic [1:0] SelShr  = 2'b01;
    localparam logic [1:0] SelShl  = 2'b10;
    localparam logic [1:0] SelLoad = 2'b11;

    state_e           state;
    logic [CNT_W-1:0] count;
    logic             sr_in_q;
    logic             multi;

`ifdef USR_ROTATE_EN
    logic rot;
    assign multi     = (cmd.cmd_op != OpLoad);
    // Rotation feeds back the live LSB so each cycle sees the freshly shifted value.
    assign usr_sr_in = rot ? usr_q[0] : sr_in_q;
`else
    logic unused_usr_q;
    assign multi        = (cmd.cmd_op == OpShr) || (cmd.cmd_op == OpShl);
    assign usr_sr_in    = sr_in_q;
    assign unused_usr_q = ^usr_q;
`endif

    assign cmd.cmd_ready = (state == StIdle);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= StIdle;
            count     <= '0;
            usr_sel   <= SelHold;
            usr_pdata <= '0;
            sr_in_q   <= 1'b0;
            usr_sl_in <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef USR_ROTATE_EN
            rot       <= 1'b0;
`endif
        end else begin
            unique case (state)
                StIdle: begin
                    if (cmd.cmd_valid) begin
                        busy <= 1'b1;
                        if (multi && cmd.cmd_cnt == '0) begin
                            state <= StDone;
                            done  <= 1'b1;
                        end else begin
                            state <= StExec;
                            // Single-cycle ops load 1 so EXEC always ends on count==1.
                            count <= multi ? cmd.cmd_cnt : CNT_W'(1);
                            unique case (cmd.cmd_op)
                                OpLoad: begin
                                    usr_sel   <= SelLoad;
                                    usr_pdata <= cmd.cmd_din;
                                end
                                OpShr: begin
                                    usr_sel <= SelShr;
                                    sr_in_q <= cmd.cmd_sin;
                                end
                                OpShl: begin
                                    usr_sel   <= SelShl;
                                    usr_sl_in <= cmd.cmd_sin;
                                end
                                default: begin
`ifdef USR_ROTATE_EN
                                    usr_sel <= SelShr;
                                    rot     <= 1'b1;
`else
                                    usr_sel   <= SelLoad;
                                    usr_pdata <= '0;
`endif
                                end
                            endcase
                        end
                    end
                end
                StExec: begin
                    if (count == CNT_W'(1)) begin
                        state     <= StDone;
                        done      <= 1'b1;
                        usr_sel   <= SelHold;
                        usr_pdata <= '0;
                        sr_in_q   <= 1'b0;
                        usr_sl_in <= 1'b0;
`ifdef USR_ROTATE_EN
                        rot       <= 1'b0;
`endif
                    end else begin
                        count <= count - CNT_W'(1);
                    end
                end
                StDone: begin
                    state <= StIdle;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_usr_ctrl.sv
// Bench for usr_ctrl: directed plus random commands checked against a behavioural model
// of the register contents and the per-cycle control sequence.
module tb_usr_ctrl;
    localparam int unsigned WIDTH = 4;
    localparam int unsigned CNT_W = 3;
`ifdef USR_ROTATE_EN
    localparam bit Rot = 1'b1;
`else
    localparam bit Rot = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    usr_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) cmd_if ();

    logic [WIDTH-1:0] usr_q;
    logic [1:0]       usr_sel;
    logic [WIDTH-1:0] usr_pdata;
    logic             usr_sr_in;
    logic             usr_sl_in;
    logic             busy;
    logic             done;

    usr_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd       (cmd_if.slave),
        .usr_q     (usr_q),
        .usr_sel   (usr_sel),
        .usr_pdata (usr_pdata),
        .usr_sr_in (usr_sr_in),
        .usr_sl_in (usr_sl_in),
        .busy      (busy),
        .done      (done)
    );

    // Stand-in for the dff-based universal shift register.
    always_ff @(posedge clk) begin
        case (usr_sel)
            2'b01:   usr_q <= {usr_sr_in, usr_q[WIDTH-1:1]};
            2'b10:   usr_q <= {usr_q[WIDTH-2:0], usr_sl_in};
            2'b11:   usr_q <= usr_pdata;
            default: usr_q <= usr_q;
        endcase
    end

    int vectors = 0;
    int miscompares = 0;
    logic [WIDTH-1:0] model_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [CNT_W-1:0] cnt,
                           input logic [WIDTH-1:0] din, input logic sin, input bit hold_valid);
        int  guard;
        int  n;
        bit  is_multi;
        logic [1:0] exp_sel;
        logic exp_sr;
        logic exp_sl;
        guard = 0;
        while (cmd_if.cmd_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before", 32'(cmd_if.cmd_ready), 32'd1);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_cnt   = cnt;
        cmd_if.cmd_din   = din;
        cmd_if.cmd_sin   = sin;
        @(negedge clk);
        is_multi = (op == 2'b01) || (op == 2'b10) || (Rot && op == 2'b11);
        n = is_multi ? int'(cnt) : 1;
        for (int i = 0; i < n; i++) begin
            // Command inputs wander while busy; none of it may be taken.
            cmd_if.cmd_valid = hold_valid;
            cmd_if.cmd_op    = 2'($urandom);
            cmd_if.cmd_cnt   = CNT_W'($urandom);
            cmd_if.cmd_din   = WIDTH'($urandom);
            cmd_if.cmd_sin   = 1'($urandom);
            exp_sr = 1'b0;
            exp_sl = 1'b0;
            case (op)
                2'b00:   exp_sel = 2'b11;
                2'b01: begin exp_sel = 2'b01; exp_sr = sin; end
                2'b10: begin exp_sel = 2'b10; exp_sl = sin; end
                default: if (Rot) begin exp_sel = 2'b01; exp_sr = model_q[0]; end
                         else exp_sel = 2'b11;
            endcase
            check("exec_sel", 32'(usr_sel), 32'(exp_sel));
            check("exec_busy", 32'(busy), 32'd1);
            check("exec_done", 32'(done), 32'd0);
            check("exec_ready", 32'(cmd_if.cmd_ready), 32'd0);
            if (exp_sel == 2'b11)
                check("exec_pdata", 32'(usr_pdata), 32'(op == 2'b00 ? din : '0));
            else begin
                check("exec_sr_in", 32'(usr_sr_in), 32'(exp_sr));
                check("exec_sl_in", 32'(usr_sl_in), 32'(exp_sl));
            end
            case (op)
                2'b00:   model_q = din;
                2'b01:   model_q = {sin, model_q[WIDTH-1:1]};
                2'b10:   model_q = {model_q[WIDTH-2:0], sin};
                default: model_q = Rot ? {model_q[0], model_q[WIDTH-1:1]} : '0;
            endcase
            @(negedge clk);
        end
        cmd_if.cmd_valid = 1'b0;
        check("done_pulse", 32'(done), 32'd1);
        check("done_sel", 32'(usr_sel), 32'd0);
        check("done_busy", 32'(busy), 32'd1);
        check("done_ready", 32'(cmd_if.cmd_ready), 32'd0);
        @(negedge clk);
        check("ready_after", 32'(cmd_if.cmd_ready), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check("reg_value", 32'(usr_q), 32'(model_q));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = '0;
        cmd_if.cmd_cnt   = '0;
        cmd_if.cmd_din   = '0;
        cmd_if.cmd_sin   = 1'b0;
        model_q          = '0;
        repeat (2) @(negedge clk);
        check("rst_sel", 32'(usr_sel), 32'd0);
        check("rst_pdata", 32'(usr_pdata), 32'd0);
        check("rst_sr_in", 32'(usr_sr_in), 32'd0);
        check("rst_sl_in", 32'(usr_sl_in), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready", 32'(cmd_if.cmd_ready), 32'd1);
        rst = 1'b1;
        @(negedge clk);

        run_cmd(2'b00, 3'd0, 4'b1011, 1'b0, 1'b0);
        check("load_1011", 32'(usr_q), 32'hb);
        run_cmd(2'b01, 3'd2, 4'b0000, 1'b0, 1'b0);
        check("shr2_0010", 32'(usr_q), 32'h2);
        run_cmd(2'b00, 3'd0, 4'b0000, 1'b0, 1'b0);
        run_cmd(2'b10, 3'd5, 4'b0000, 1'b1, 1'b1);
        check("shl5_1111", 32'(usr_q), 32'hf);
        run_cmd(2'b01, 3'd0, 4'b0000, 1'b0, 1'b1);
        check("shift0_keep", 32'(usr_q), 32'hf);
        run_cmd(2'b11, 3'd3, 4'b0110, 1'b1, 1'b1);

        // Asynchronous reset in the second cycle of a 4-cycle shift.
        run_cmd(2'b00, 3'd0, 4'b0101, 1'b0, 1'b0);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = 2'b01;
        cmd_if.cmd_cnt   = 3'd4;
        cmd_if.cmd_sin   = 1'b1;
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        check("abort_c1_sel", 32'(usr_sel), 32'd1);
        model_q = {1'b1, model_q[WIDTH-1:1]};
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("abort_sel", 32'(usr_sel), 32'd0);
        check("abort_sr_in", 32'(usr_sr_in), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_ready", 32'(cmd_if.cmd_ready), 32'd1);
        repeat (3) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 32'd0);
        end
        check("abort_reg", 32'(usr_q), 32'(model_q));
        rst = 1'b1;
        @(negedge clk);

        run_cmd(2'b00, 3'd0, 4'b0001, 1'b0, 1'b0);
        run_cmd(2'b11, 3'd1, 4'b0000, 1'b0, 1'b0);
        check("op11_result", 32'(usr_q), Rot ? 32'h8 : 32'h0);

        for (int k = 0; k < 25; k++) begin
            run_cmd(2'($urandom), CNT_W'($urandom), WIDTH'($urandom), 1'($urandom),
                    1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/usr_ctrl.md
Name: usr_ctrl

Overview:
Command sequencer for the 4-bit universal shift register built from the team's dff cells. It accepts one command at a time over a valid/ready interface and drives the register's mode select, parallel data and serial fill inputs. Supported commands are parallel load, multi-cycle shift right or left, and clear. It reports completion with a one-cycle done pulse, which lets upstream logic treat the shift register as a transaction-level resource.

Parameters:
WIDTH, 4, register width in bits; the width of cmd_din, usr_pdata and usr_q.
CNT_W, 3, width of the shift-count field; the maximum count is 2^CNT_W-1.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-low reset (asserted at 0).
cmd_valid  input  1  command present.
cmd_ready  output  1  controller can accept a command; high only in IDLE.
cmd_op  input  2  00 load, 01 shift right, 10 shift left, 11 clear (rotate right under the macro).
cmd_cnt  input  CNT_W  number of shift cycles; ignored for load and clear.
cmd_din  input  WIDTH  parallel load data.
cmd_sin  input  1  serial fill bit used for shifts.
usr_q  input  WIDTH  current register contents; used only under the macro.
usr_sel  output  2  register mode: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
usr_pdata  output  WIDTH  parallel data presented to the register.
usr_sr_in  output  1  serial input entering at the MSB on shift right.
usr_sl_in  output  1  serial input entering at the LSB on shift left.
busy  output  1  high in EXEC and DONE.
done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (rst=0, asynchronous):
  - state goes to IDLE.
  - usr_sel=00, usr_pdata=0, usr_sr_in=0, usr_sl_in=0, busy=0, done=0, internal counter=0.
  - cmd_ready=1, decoded from the IDLE state.
- Reset during EXEC or DONE aborts the command immediately, with no done pulse.
- All outputs except cmd_ready are registered. cmd_ready = (state==IDLE).
- States: IDLE, EXEC, DONE.
- IDLE:
  - Handshake is cmd_valid && cmd_ready at a rising edge.
  - On handshake, capture op, cnt, din and sin, then go to EXEC.
  - Exception: a shift with cnt=0 goes straight to DONE with usr_sel staying 00.
  - With no handshake, stay in IDLE with usr_sel=00.
- EXEC, load: one cycle with usr_sel=11 and usr_pdata=din, then DONE.
- EXEC, clear: one cycle with usr_sel=11 and usr_pdata=0, then DONE.
- EXEC, shift right or left: exactly cnt cycles with usr_sel=01 or 10.
  - The fill bit sits on usr_sr_in (right) or usr_sl_in (left); the unused serial input is 0.
  - The counter loads cnt and decrements each cycle; the transition to DONE happens when the counter reaches 1.
- DONE: one cycle with done=1, usr_sel=00 and cmd_ready=0, then IDLE.
- Latency, from the handshake edge (edge 0):
  - Load or clear: usr_sel=11 in the cycle after edge 0, done in the cycle after that, cmd_ready high again one cycle later. The minimum command-to-command spacing is 3 cycles.
  - Shift: cnt+2 cycles from handshake to the next cmd_ready.
- Commands presented while cmd_ready=0 are not accepted and produce no side effects; cmd_valid may remain high.
- cnt greater than WIDTH is legal. The register simply shifts cnt times, so it ends fully filled with the fill bit.
- Captured operands are frozen for the whole command. Changes on cmd_* during EXEC or DONE have no effect.
- busy = (state!=IDLE); it is the complement of cmd_ready outside reset.

Optional Feature:
USR_ROTATE_EN
- Defined: cmd_op=11 means rotate right by cnt.
  - Each EXEC cycle drives usr_sel=01 and usr_sr_in=usr_q[0], sampled live every cycle.
  - cnt=0 behaves like a zero-count shift.
- Undefined: cmd_op=11 is clear as described above. usr_q is unused, and tools may report it as unloaded.

Test Plan:
- Reset release, then load cmd_din=4'b1011 -> one cycle of usr_sel=11 with usr_pdata=1011; done pulses the next cycle; register reads 1011; cmd_ready returns 3 cycles after the handshake.
- After loading 1011, shift right with cnt=2 and sin=0 -> usr_sel=01 for exactly 2 cycles with usr_sr_in=0; register ends at 0010; single done pulse.
- Shift left with cnt=5 and sin=1 from 0000 -> usr_sel=10 for 5 cycles with usr_sl_in=1; register ends at 1111; no other command is accepted while busy=1, even with cmd_valid held high.
- Shift with cnt=0 -> usr_sel stays 00; done pulses in the cycle after the handshake; register is unchanged.
- Drive rst=0 mid-shift (cycle 2 of 4) -> all outputs go to their reset values asynchronously; no done pulse; a fresh load is accepted after release.
- With USR_ROTATE_EN defined, load 0001 then op=11 with cnt=1 -> usr_sr_in=1; register ends at 1000. Without the macro, the same op produces 0000.
